// File: rtl/instruction_fetch.sv
// Purpose : IF stage - PC register with stall/redirect plus the IF/ID pipeline register.
// Latency : one cycle from IMem_Addr to Instruction_IFID; the PC updates every unstalled cycle.
// Backpr. : Stall_PC holds the PC and Stall_IF_ID holds IF/ID; a held PC with a free IF/ID inserts a bubble.
//
// Ports:
//   Clock, Reset (sync, active-low)   - clock and reset
//   PCSel, BranchPC                   - redirect request and target from decode
//   Stall_PC, Stall_IF_ID             - hazard-unit stalls for the PC and the IF/ID register
//   IMem_Addr / IMem_Data             - combinational instruction-memory read port
//   Instruction_IFID, PCPlusFour_IFID,
//   Valid_IFID                        - IF/ID register presented to decode
//   PC_Current                        - current PC register value
//   FetchCount, BubbleCount           - saturating perf counters, present only with IF_PERF_COUNT_EN
//
// Optional feature macro: IF_PERF_COUNT_EN
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PCSel,
  input  logic [31:0] BranchPC,
  input  logic        Stall_PC,
  input  logic        Stall_IF_ID,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instruction_IFID,
  output logic [31:0] PCPlusFour_IFID,
  output logic        Valid_IFID,
`ifdef IF_PERF_COUNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
`endif
  output logic [31:0] PC_Current
);

  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic [31:0] next_pc;
  logic        ifid_bubble;
  logic        ifid_load;

  // Wraps naturally modulo 2^32.
  assign pc_plus_four = pc + 32'd4;

  assign IMem_Addr  = pc;
  assign PC_Current = pc;

  // A stalled PC ignores PCSel; decode keeps asserting it until the stall clears.
  always_comb begin
    next_pc = pc_plus_four;
    if (Stall_PC) begin
      next_pc = pc;
    end else if (PCSel) begin
      next_pc = {BranchPC[31:2], 2'b00};
    end
  end

  // Bubble when the sequential fetch in flight is being flushed by a redirect,
  // or when the PC is held but the IF/ID register is free to move.
  assign ifid_bubble = !Stall_IF_ID && (Stall_PC || PCSel);
  assign ifid_load   = !Stall_IF_ID && !Stall_PC && !PCSel;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Instruction_IFID <= 32'h00000000;
      PCPlusFour_IFID  <= 32'h00000000;
      Valid_IFID       <= 1'b0;
    end else if (ifid_bubble) begin
      Instruction_IFID <= 32'h00000000;
      PCPlusFour_IFID  <= 32'h00000000;
      Valid_IFID       <= 1'b0;
    end else if (ifid_load) begin
      Instruction_IFID <= IMem_Data;
      PCPlusFour_IFID  <= pc_plus_four;
      Valid_IFID       <= 1'b1;
    end
    // Otherwise Stall_IF_ID holds all three outputs.
  end

`ifdef IF_PERF_COUNT_EN
  // Hold cycles count as bubbles: decode receives no new instruction either way.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      FetchCount  <= 32'h00000000;
      BubbleCount <= 32'h00000000;
    end else if (ifid_load) begin
      if (FetchCount != 32'hFFFFFFFF) begin
        FetchCount <= FetchCount + 32'd1;
      end
    end else begin
      if (BubbleCount != 32'hFFFFFFFF) begin
        BubbleCount <= BubbleCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] BranchPC = 32'h0;
  logic        Stall_PC = 1'b0;
  logic        Stall_IF_ID = 1'b0;
  logic [31:0] IMem_Addr;
  logic [31:0] IMem_Data;
  logic [31:0] Instruction_IFID;
  logic [31:0] PCPlusFour_IFID;
  logic        Valid_IFID;
  logic [31:0] PC_Current;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int checks = 0;
  int failures = 0;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .PCSel            (PCSel),
    .BranchPC         (BranchPC),
    .Stall_PC         (Stall_PC),
    .Stall_IF_ID      (Stall_IF_ID),
    .IMem_Addr        (IMem_Addr),
    .IMem_Data        (IMem_Data),
    .Instruction_IFID (Instruction_IFID),
    .PCPlusFour_IFID  (PCPlusFour_IFID),
    .Valid_IFID       (Valid_IFID),
`ifdef IF_PERF_COUNT_EN
    .FetchCount       (FetchCount),
    .BubbleCount      (BubbleCount),
`endif
    .PC_Current       (PC_Current)
  );

  always #5 Clock = ~Clock;

  // Instruction memory: address 0 holds the reset-sequence word, everything else is a scrambled pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h01000193;
  endfunction

  assign IMem_Data = imem(IMem_Addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ppf;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_ppf, m_fc, m_bc;
  logic        m_valid;
  bit          stim_done = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic step(input bit rst_n, input bit sel, input logic [31:0] bpc,
                      input bit spc, input bit sif);
    exp_t e;
    logic [31:0] fetched, seq;
    @(negedge Clock);
    Reset = rst_n; PCSel = sel; BranchPC = bpc; Stall_PC = spc; Stall_IF_ID = sif;
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = 0; m_ppf = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    end else begin
      fetched = imem(m_pc);
      seq     = m_pc + 32'd4;
      if (!sif && !spc && !sel) begin
        m_instr = fetched; m_ppf = seq; m_valid = 1;
        if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 1;
      end else begin
        if (!sif) begin
          m_instr = 0; m_ppf = 0; m_valid = 0;
        end
        if (m_bc != 32'hFFFFFFFF) m_bc = m_bc + 1;
      end
      if (!spc) m_pc = sel ? {bpc[31:2], 2'b00} : seq;
    end
    e.pc = m_pc; e.instr = m_instr; e.ppf = m_ppf; e.valid = m_valid; e.fc = m_fc; e.bc = m_bc;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per rising edge after stimulus begins.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("pc_current", PC_Current, e.pc);
        check32("imem_addr", IMem_Addr, e.pc);
        check32("instruction_ifid", Instruction_IFID, e.instr);
        check32("pcplusfour_ifid", PCPlusFour_IFID, e.ppf);
        check32("valid_ifid", {31'b0, Valid_IFID}, {31'b0, e.valid});
`ifdef IF_PERF_COUNT_EN
        check32("fetch_count", FetchCount, e.fc);
        check32("bubble_count", BubbleCount, e.bc);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit sel, spc, sif, rst;
    logic [31:0] bpc;
    // Reset sequence, then first fetch of 0x20080005.
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);             // PC 4 -> 8
    // Redirect at PC=8 to 0x41 (aligned to 0x40), then load 0x40.
    step(1, 1, 32'h00000041, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Reach PC=12 and stall both with PCSel asserted.
    step(1, 1, 32'h0000000C, 0, 0);
    step(1, 1, 32'h00000100, 1, 1);
    step(1, 1, 32'h00000100, 1, 1);
    step(1, 1, 32'h00000100, 1, 1);
    // Split stall: PC held, IF/ID takes a bubble.
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    // IF/ID-only stall while the PC advances.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    // Wrap from 0xFFFFFFFC.
    step(1, 1, 32'hFFFFFFFF, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Reset together with PCSel and stalls mid-operation.
    step(0, 1, 32'h00000800, 0, 0);
    step(0, 1, 32'h00000800, 1, 1);
    step(1, 0, 0, 0, 0);
    // Counter scenario: 10 free-running cycles plus 2 stall cycles.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) >= 3);
      sel = ($urandom_range(0, 99) < 20);
      spc = ($urandom_range(0, 99) < 20);
      sif = ($urandom_range(0, 99) < 15);
      bpc = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
      step(rst, sel, bpc, spc, sif);
    end
    // Drain: let the monitor consume the last expectation, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clock);
    #2;
    check32("queue_drained", exp_q.size(), 0);
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
